// File: rtl/fifo_transmitter.sv
// UART transmit-side FIFO: CPU pushes bytes, an FSM hands them one at a time
// to the transmitter with a tx_start pulse and waits for tx_done.
module fifo_transmitter #(
   parameter int DB = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DB-1:0] w_data,
   input  logic          wr,
   output logic          tx_full,
   output logic          tx_empty,
   output logic          tx_busy,
   output logic [DB-1:0] d_in,
   output logic          tx_start,
   input  logic          tx_done
);
   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

   state_t        state, state_next;
   logic [DB-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          wr_ok, deq;

   // Flags come from the registered count, so they describe the pre-edge state.
   assign tx_full  = (count == FULL_CNT);
   assign tx_empty = (count == '0);
   assign wr_ok    = wr && !tx_full;

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= w_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         d_in   <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (deq) begin
            rd_ptr <= rd_ptr + AW'(1);
            d_in   <= mem[rd_ptr];
         end
         case ({wr_ok, deq})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (!tx_empty) state_next = START;
         START:     state_next = WAIT_DONE;
         WAIT_DONE: if (tx_done) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // tx_start decodes the START state, which lasts exactly one cycle.
   always_comb begin
      deq      = (state == IDLE) && !tx_empty;
      tx_start = (state == START);
      tx_busy  = (state != IDLE);
   end

endmodule
